// File: rtl/fault_sim_pkg.sv
// rtl/fault_sim_pkg.sv - shared types and helpers for the fault-simulation sequencer
package fault_sim_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GEN,
        S_INJECT,
        S_SAMPLE,
        S_REMOVE,
        S_UPDATE,
        S_COMMIT,
        S_CHECK,
        S_DONE
    } state_e;

    // Taps 32,22,2,1 expressed as bit positions 31,21,1,0
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [31:0] next_exp(input logic [31:0] nw, input logic [31:0] ex);
        return (nw < ex) ? (ex >> 1) : 32'((33'(nw) + 33'(ex)) >> 1);
    endfunction

    function automatic logic cov_met(input logic [31:0] det, input int unsigned target,
                                     input int unsigned nfaults);
        return (64'(det) * 64'd100) >= (64'(target) * 64'(nfaults));
    endfunction

endpackage

// File: rtl/fault_sim_sequencer_if.sv
// rtl/fault_sim_sequencer_if.sv - CUT-side bus between sequencer and good/faulty netlists
interface fault_sim_sequencer_if #(
    parameter int unsigned IN_W   = 178,
    parameter int unsigned OUT_W  = 123,
    parameter int unsigned FIDX_W = 13
);
    logic [IN_W-1:0]   test_vec;
    logic [FIDX_W-1:0] fault_idx;
    logic              fault_inj_en;
    logic [OUT_W-1:0]  good_out;
    logic [OUT_W-1:0]  faulty_out;

    modport master (output test_vec, fault_idx, fault_inj_en, input good_out, faulty_out);
    modport slave  (input test_vec, fault_idx, fault_inj_en, output good_out, faulty_out);
endinterface

// File: rtl/fault_sim_lfsr.sv
// rtl/fault_sim_lfsr.sv - 32-bit Fibonacci LFSR replicated across the CUT input width
module fault_sim_lfsr
    import fault_sim_pkg::*;
#(
    parameter int unsigned IN_W = 178,
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic            clk,
    input  logic            load_seed_i,
    input  logic            advance_i,
    output logic [IN_W-1:0] vec_o
);
    logic [31:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (load_seed_i)    lfsr_q <= SEED;
        else if (advance_i) lfsr_q <= lfsr_step(lfsr_q);
    end

    for (genvar i = 0; i < IN_W; i++) begin : g_rep
        assign vec_o[i] = lfsr_q[i % 32];
    end
endmodule

// File: rtl/fault_sim_sequencer.sv
// rtl/fault_sim_sequencer.sv - adaptive random-pattern fault simulation controller
module fault_sim_sequencer
    import fault_sim_pkg::*;
#(
    parameter int unsigned IN_W       = 178,
    parameter int unsigned OUT_W      = 123,
    parameter int unsigned NUM_FAULTS = 5104,
    parameter int unsigned FIDX_W     = 13,
    parameter int unsigned INIT_EXP   = 2,
    parameter int unsigned UT_LIMIT   = 20,
    parameter int unsigned COV_TARGET = 90,
    parameter int unsigned SETTLE     = 6,
    parameter int unsigned REMOVE_CYC = 2,
    parameter logic [31:0] SEED       = 32'h0000_0001
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    fault_sim_sequencer_if.master  cut,
    output logic                   keep_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   cov_reached,
    output logic [15:0]            kept_count,
    output logic [15:0]            total_count,
    output logic [FIDX_W:0]        detected_count
);
    localparam int unsigned EW    = FIDX_W + 1;
    localparam int unsigned CNT_W = 8;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [FIDX_W-1:0]       fidx_q;
    logic                    inj_q, keep_q;
    logic [NUM_FAULTS-1:0]   at_map_q, ct_map_q;
    logic [EW-1:0]           new_q, exp_q, det_q;
    logic [15:0]             ut_q, kept_q, total_q;

    logic [OUT_W-1:0]        good_w, faulty_w;
    logic                    mis;
    logic [31:0]             exp_d;
    logic                    keep_d;
    logic [EW:0]             det_sum;
    logic                    run_start;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign good_w   = cut.good_out;
    assign faulty_w = cut.faulty_out;
    // Case inequality so an unknown output bit is treated as a detection
    assign mis      = (good_w !== faulty_w);

    assign exp_d     = next_exp(32'(new_q), 32'(exp_q));
    assign keep_d    = (32'(new_q) >= exp_d) && (new_q != '0);
    assign det_sum   = {1'b0, det_q} + {1'b0, new_q};
    assign run_start = start && (state_q == S_IDLE || state_q == S_DONE);

    fault_sim_lfsr #(.IN_W(IN_W), .SEED(SEED)) u_lfsr (
        .clk         (clk),
        .load_seed_i (rst),
        .advance_i   (state_q == S_GEN),
        .vec_o       (cut.test_vec)
    );

    always_ff @(posedge clk) begin
        if (rst || run_start) begin
            state_q  <= rst ? S_IDLE : S_CHECK;
            cnt_q    <= '0;
            fidx_q   <= '0;
            inj_q    <= 1'b0;
            keep_q   <= 1'b0;
            at_map_q <= '0;
            ct_map_q <= '0;
            new_q    <= '0;
            exp_q    <= EW'(INIT_EXP);
            det_q    <= '0;
            ut_q     <= '0;
            kept_q   <= '0;
            total_q  <= '0;
        end else begin
            keep_q <= 1'b0;
            case (state_q)
                S_CHECK: state_q <= (cov_reached || 32'(ut_q) >= UT_LIMIT) ? S_DONE : S_GEN;
                S_GEN: begin
                    total_q  <= sat_inc(total_q);
                    ut_q     <= sat_inc(ut_q);
                    ct_map_q <= '0;
                    new_q    <= '0;
                    fidx_q   <= '0;
                    cnt_q    <= '0;
                    inj_q    <= 1'b1;
                    state_q  <= S_INJECT;
                end
                S_INJECT: begin
                    if (cnt_q == CNT_W'(SETTLE - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    if (mis) begin
                        ct_map_q[fidx_q] <= 1'b1;
                        if (!at_map_q[fidx_q] && new_q != '1) new_q <= new_q + EW'(1);
                    end
                    inj_q   <= 1'b0;
                    state_q <= S_REMOVE;
                end
                S_REMOVE: begin
                    if (cnt_q == CNT_W'(REMOVE_CYC - 1)) begin
                        cnt_q <= '0;
                        if (fidx_q == FIDX_W'(NUM_FAULTS - 1)) begin
                            state_q <= S_UPDATE;
                        end else begin
                            fidx_q  <= fidx_q + FIDX_W'(1);
                            inj_q   <= 1'b1;
                            state_q <= S_INJECT;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_UPDATE: begin
                    exp_q   <= EW'(exp_d);
                    keep_q  <= keep_d;
                    state_q <= keep_d ? S_COMMIT : S_CHECK;
                end
                S_COMMIT: begin
                    at_map_q <= at_map_q | ct_map_q;
                    det_q    <= det_sum[EW] ? '1 : det_sum[EW-1:0];
                    kept_q   <= sat_inc(kept_q);
                    ut_q     <= '0;
                    state_q  <= S_CHECK;
                end
                S_IDLE, S_DONE: state_q <= state_q;
                default:        state_q <= S_IDLE;
            endcase
        end
    end

    assign cut.fault_idx    = fidx_q;
    assign cut.fault_inj_en = inj_q;
    assign keep_valid       = keep_q;
    assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done             = (state_q == S_DONE);
    assign cov_reached      = cov_met(32'(det_q), COV_TARGET, NUM_FAULTS);
    assign kept_count       = kept_q;
    assign total_count      = total_q;
    assign detected_count   = det_q;
endmodule

// File: tb/tb_fault_sim_sequencer.sv
// tb/tb_fault_sim_sequencer.sv - self-checking bench for fault_sim_sequencer
module tb_fault_sim_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_a = 0, start_b = 0, start_c = 0;
    logic [7:0] gval = 8'h5A;
    logic [7:0] mask_a = '0;
    logic [7:0] mask_b = 8'h0F;
    logic [3:0] tab_c [128];
    int         mode_c = 0;
    int         inj_run_c = 0;
    logic       mis_c;

    logic keep_a, busy_a, done_a, cov_a; logic [15:0] kept_a, total_a; logic [3:0] det_a;
    logic keep_b, busy_b, done_b, cov_b; logic [15:0] kept_b, total_b; logic [3:0] det_b;
    logic keep_c, busy_c, done_c, cov_c; logic [15:0] kept_c, total_c; logic [2:0] det_c;

    fault_sim_sequencer_if #(.IN_W(40), .OUT_W(8), .FIDX_W(3)) ifa ();
    fault_sim_sequencer_if #(.IN_W(40), .OUT_W(8), .FIDX_W(3)) ifb ();
    fault_sim_sequencer_if #(.IN_W(40), .OUT_W(8), .FIDX_W(2)) ifc ();

    fault_sim_sequencer #(.IN_W(40), .OUT_W(8), .NUM_FAULTS(8), .FIDX_W(3), .UT_LIMIT(3),
                          .COV_TARGET(90)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .cut(ifa), .keep_valid(keep_a), .busy(busy_a),
        .done(done_a), .cov_reached(cov_a), .kept_count(kept_a), .total_count(total_a),
        .detected_count(det_a));
    fault_sim_sequencer #(.IN_W(40), .OUT_W(8), .NUM_FAULTS(8), .FIDX_W(3), .UT_LIMIT(1),
                          .COV_TARGET(100)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cut(ifb), .keep_valid(keep_b), .busy(busy_b),
        .done(done_b), .cov_reached(cov_b), .kept_count(kept_b), .total_count(total_b),
        .detected_count(det_b));
    fault_sim_sequencer #(.IN_W(40), .OUT_W(8), .NUM_FAULTS(4), .FIDX_W(2)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .cut(ifc), .keep_valid(keep_c), .busy(busy_c),
        .done(done_c), .cov_reached(cov_c), .kept_count(kept_c), .total_count(total_c),
        .detected_count(det_c));

    // CUT stubs: a per-fault mismatch mask stands in for the netlist pair
    assign ifa.good_out   = gval;
    assign ifa.faulty_out = gval ^ {8{mask_a[ifa.fault_idx]}};
    assign ifb.good_out   = gval;
    assign ifb.faulty_out = gval ^ {8{mask_b[ifb.fault_idx]}};
    always_comb begin
        case (mode_c)
            0:       mis_c = tab_c[total_c[6:0]][ifc.fault_idx];
            1:       mis_c = (inj_run_c != 6);
            default: mis_c = (inj_run_c == 6);
        endcase
    end
    assign ifc.good_out   = gval;
    assign ifc.faulty_out = gval ^ {8{mis_c}};

    always @(posedge clk) inj_run_c <= ifc.fault_inj_en ? inj_run_c + 1 : 0;

    int          keeps_a = 0, keeps_b = 0, keeps_c = 0;
    logic [39:0] got_c [$];
    always @(negedge clk) begin
        if (keep_a) keeps_a++;
        if (keep_b) keeps_b++;
        if (keep_c) begin keeps_c++; got_c.push_back(ifc.test_vec); end
    end

    int n_tests = 0, n_fail = 0;
    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int sel = 0;
    logic done_sel;
    always_comb done_sel = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;

    task automatic pulse_start(input int which);
        @(negedge clk);
        sel = which;
        if (which == 0) start_a = 1; else if (which == 1) start_b = 1; else start_c = 1;
        @(negedge clk);
        start_a = 0; start_b = 0; start_c = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_sel) break;
            @(negedge clk);
        end
        check({name, " done"}, done_sel, 1);
    endtask

    typedef struct {
        logic [7:0] mask;
        int total; int kept; int det; int cov; int keeps;
    } vec_t;
    vec_t tbl [5];

    logic [31:0] mlf;
    logic [39:0] exp_vecs [$];
    int          base_k, base_g, e, at, det, kept, tot, ut, nw;
    bit          h [256];
    int          fid [256];
    int          ncyc, kc, runs, bad_len, bad_gap, bad_fid, first, len, gap;

    initial begin
        for (int v = 0; v < 128; v++) tab_c[v] = '0;
        tbl[0] = '{8'hFF, 1, 1, 8, 1, 1};
        tbl[1] = '{8'h00, 3, 0, 0, 0, 0};
        tbl[2] = '{8'h0F, 4, 1, 4, 0, 1};
        tbl[3] = '{8'h01, 4, 1, 1, 0, 1};
        tbl[4] = '{8'h07, 4, 1, 3, 0, 1};

        repeat (3) @(negedge clk);
        rst = 0;
        check("rst inj_en", ifc.fault_inj_en, 0);
        check("rst busy/done", {busy_a, done_a, busy_c, done_c}, 0);
        check("rst keep", {keep_a, keep_b, keep_c}, 0);
        check("rst counts", {kept_c, total_c, det_c, kept_a, total_a, det_a}, 0);
        check("rst test_vec", ifc.test_vec, 40'h01_0000_0001);

        // fixed-mask runs on the 8-fault / UT_LIMIT=3 instance
        for (int i = 0; i < 5; i++) begin
            mask_a = tbl[i].mask;
            base_k = keeps_a;
            pulse_start(0);
            wait_done($sformatf("A%0d", i), 2000);
            check($sformatf("A%0d total", i), total_a, tbl[i].total);
            check($sformatf("A%0d kept", i), kept_a, tbl[i].kept);
            check($sformatf("A%0d det", i), det_a, tbl[i].det);
            check($sformatf("A%0d cov", i), cov_a, tbl[i].cov);
            check($sformatf("A%0d keeps", i), keeps_a - base_k, tbl[i].keeps);
        end

        // redundant second vector
        base_k = keeps_b;
        pulse_start(1);
        wait_done("B", 2000);
        check("B total", total_b, 2);
        check("B kept", kept_b, 1);
        check("B det", det_b, 4);
        check("B cov", cov_b, 0);
        check("B keeps", keeps_b - base_k, 1);

        // reset while fault 3 is injected
        mode_c = 0;
        pulse_start(2);
        for (int i = 0; i < 300; i++) begin
            if (ifc.fault_idx == 3 && ifc.fault_inj_en) break;
            @(negedge clk);
        end
        check("midrst reached f3", ifc.fault_idx == 3 && ifc.fault_inj_en, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("midrst inj_en", ifc.fault_inj_en, 0);
        check("midrst busy", busy_c, 0);
        check("midrst counts", {kept_c, total_c, det_c}, 0);
        pulse_start(2);
        for (int i = 0; i < 10; i++) begin
            if (total_c != 0) break;
            @(negedge clk);
        end
        check("restart total", total_c, 1);
        check("restart fidx", ifc.fault_idx, 0);
        rst = 1; @(negedge clk); rst = 0;

        // timing profile, detection only visible in the sample cycle
        mode_c = 2;
        pulse_start(2);
        ncyc = 0; kc = -1;
        for (int i = 0; i < 256; i++) begin
            h[i] = ifc.fault_inj_en; fid[i] = int'(ifc.fault_idx);
            if (keep_c && kc < 0) kc = i;
            ncyc = i + 1;
            if (done_c) break;
            @(negedge clk);
        end
        runs = 0; bad_len = 0; bad_gap = 0; bad_fid = 0; first = -1; len = 0; gap = -1;
        for (int i = 0; i < ncyc; i++) begin
            if (h[i]) begin
                if (len == 0) begin
                    if (first < 0) first = i;
                    if (runs > 0 && gap != 2) bad_gap++;
                end
                len++;
                if (fid[i] != runs) bad_fid++;
            end else begin
                if (len > 0) begin
                    if (len != 7) bad_len++;
                    runs++; len = 0; gap = 0;
                end
                if (gap >= 0) gap++;
            end
        end
        check("timing done", done_c, 1);
        check("timing runs", runs, 4);
        check("timing run len", bad_len, 0);
        check("timing gap len", bad_gap, 0);
        check("timing fidx stable", bad_fid, 0);
        check("timing inject-to-keep", kc - first, 37);
        check("timing det", det_c, 4);
        check("timing kept", kept_c, 1);

        // glitches outside the sample cycle must be ignored
        mode_c = 1;
        base_k = keeps_c;
        pulse_start(2);
        wait_done("glitch", 3000);
        check("glitch total", total_c, 20);
        check("glitch det", det_c, 0);
        check("glitch keeps", keeps_c - base_k, 0);

        // randomized masks against a vector-level model
        rst = 1; @(negedge clk); rst = 0;
        mode_c = 0;
        mlf = 32'h0000_0001;
        for (int r = 0; r < 6; r++) begin
            for (int v = 0; v < 128; v++)
                tab_c[v] = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            exp_vecs.delete();
            e = 2; at = 0; det = 0; kept = 0; tot = 0; ut = 0;
            while (!(det * 100 >= 90 * 4) && ut < 20) begin
                mlf = {mlf[30:0], mlf[31] ^ mlf[21] ^ mlf[1] ^ mlf[0]};
                tot++; ut++;
                nw = $countones(tab_c[tot] & ~4'(at));
                e = (nw < e) ? e / 2 : (nw + e) / 2;
                if (nw >= e && nw > 0) begin
                    at = at | int'(tab_c[tot]);
                    det += nw; kept++; ut = 0;
                    exp_vecs.push_back({mlf[7:0], mlf});
                end
            end
            base_k = keeps_c; base_g = got_c.size();
            pulse_start(2);
            wait_done($sformatf("R%0d", r), 20000);
            check($sformatf("R%0d total", r), total_c, tot);
            check($sformatf("R%0d kept", r), kept_c, kept);
            check($sformatf("R%0d det", r), det_c, det);
            check($sformatf("R%0d cov", r), cov_c, (det * 100 >= 360) ? 1 : 0);
            check($sformatf("R%0d keeps", r), keeps_c - base_k, kept);
            for (int k = 0; k < exp_vecs.size() && base_g + k < got_c.size(); k++)
                check($sformatf("R%0d vec%0d", r, k), got_c[base_g + k], exp_vecs[k]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fault_sim_sequencer.md
Name: fault_sim_sequencer

Overview:
- Synthesizable controller that runs adaptive random-pattern fault simulation on a good/faulty CUT pair, such as the c5315 netlists.
- Per pass it generates one pseudo-random test vector, then walks every fault index through inject / settle / compare / remove.
- It accumulates per-vector and cumulative detected bitmaps, applies the halving expected-discovery threshold, and emits kept vectors.
- Stops when the coverage target is met or too many consecutive vectors are useless.

Parameters:
- IN_W, 178, CUT input width
- OUT_W, 123, CUT output width
- NUM_FAULTS, 5104, fault-list length
- FIDX_W, 13, fault index width, must satisfy 2^FIDX_W >= NUM_FAULTS
- INIT_EXP, 2, initial expected-new-faults threshold
- UT_LIMIT, 20, consecutive unkept vectors before giving up
- COV_TARGET, 90, target coverage in percent
- SETTLE, 6, cycles fault_inj_en is held before sampling
- REMOVE_CYC, 2, cycles fault_inj_en is held low between faults
- SEED, 32'h0000_0001, LFSR reset value, must be nonzero

Ports:
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- start, in, 1, pulse that begins a run from IDLE or DONE
- test_vec, out, IN_W, current vector: 32-bit LFSR state replicated and truncated, bit 0 = lfsr[0]
- fault_idx, out, FIDX_W, fault currently injected, 0-based
- fault_inj_en, out, 1, inject fault_idx into the faulty CUT
- good_out, in, OUT_W, good-CUT outputs
- faulty_out, in, OUT_W, faulty-CUT outputs
- keep_valid, out, 1, one-cycle pulse; test_vec is a kept vector
- busy, out, 1, high from start until DONE
- done, out, 1, level, high in DONE
- cov_reached, out, 1, detected*100 >= COV_TARGET*NUM_FAULTS
- kept_count, out, 16, vectors kept
- total_count, out, 16, vectors tried
- detected_count, out, FIDX_W+1, cumulative detected faults

Behaviour:
- Reset:
  - All counters, flags, keep_valid and fault_inj_en are 0.
  - Both bitmaps are cleared, lfsr = SEED, exp = INIT_EXP, state = IDLE.
  - Reset mid-pass aborts immediately with no partial commit.
- States: IDLE, GEN, INJECT, SAMPLE, REMOVE, UPDATE, COMMIT, CHECK, DONE.
- IDLE or DONE with start: clear all run state (as reset, except lfsr keeps its current value), then go to CHECK.
- CHECK:
  - If cov_reached or ut >= UT_LIMIT: go to DONE.
  - Otherwise: go to GEN.
- GEN (1 cycle):
  - Advance the LFSR using Fibonacci taps 32,22,2,1 with the shift toward the MSB.
  - Increment total_count and ut; clear ct_map; set new = 0, fault_idx = 0.
- INJECT:
  - fault_inj_en = 1 for SETTLE cycles, then go to SAMPLE.
- SAMPLE (1 cycle, fault_inj_en still 1):
  - If good_out != faulty_out: set ct_map[fault_idx].
  - If additionally at_map[fault_idx] == 0: new++.
- REMOVE:
  - fault_inj_en = 0 for REMOVE_CYC cycles.
  - On the last cycle: if fault_idx == NUM_FAULTS-1, go to UPDATE; otherwise fault_idx++ and go to INJECT.
- Per-fault cost is SETTLE+1+REMOVE_CYC cycles; fault_idx and test_vec are stable throughout.
- UPDATE (1 cycle):
  - exp_next = (new < exp) ? exp>>1 : (new+exp)>>1, using unsigned floor.
  - Register exp = exp_next.
  - Keep if new >= exp_next and new > 0; if kept go to COMMIT, otherwise go to CHECK.
- COMMIT (1 cycle):
  - at_map |= ct_map; detected_count += new; kept_count++; ut = 0.
  - keep_valid = 1 with test_vec held; then go to CHECK.
- cov_reached is combinational on detected_count; no divider.
- Counters saturate at their maximum value; they never wrap.
- start outside IDLE/DONE is ignored.
- X on good_out or faulty_out counts as a mismatch.

Decomposition:
- Package fault_sim_pkg holds:
  - the state enum;
  - LFSR tap constants;
  - a function for the threshold update;
  - a function for the coverage compare.
- One sub-module, fault_sim_lfsr:
  - 32-bit, with a load-seed input and an advance input;
  - drives the replicated IN_W vector.
- Both bitmaps are NUM_FAULTS-bit registers in the top level.

Test Plan:
- Reset mid-pass: assert rst during INJECT of fault 3 -> next cycle fault_inj_en=0, busy=0, all counts 0; a following start begins with total_count=1 and fault_idx=0.
- Full detection: NUM_FAULTS=8, stub always mismatches -> new=8, exp 2->5, keep_valid pulses once, detected_count=8, cov_reached=1, done with total_count=1, kept_count=1.
- Never detects: NUM_FAULTS=8, UT_LIMIT=3, stub never mismatches -> exp 2->1->0->0, done after total_count=3, kept_count=0, no keep_valid.
- Redundant vector: NUM_FAULTS=8, COV_TARGET=100, UT_LIMIT=1:
  - Vector 1 mismatches faults 0-3 -> new=4, exp 2->3, kept, detected_count=4.
  - Vector 2 mismatches faults 0-3 -> new=0, exp 3->1, not kept.
  - Final state: done, total_count=2, kept_count=1.
- Timing: SETTLE=6, REMOVE_CYC=2, NUM_FAULTS=4 -> fault_inj_en high exactly 7 cycles per fault and low 2; GEN-to-UPDATE spans 36 cycles; compare is sampled only in the SAMPLE cycle (mismatch glitches during INJECT are ignored).
